l2_pool_collector: RTL and testbench

- Consumes the 12-bit per-window results of the layer-2 MAC stage, one result per completed window, in raster order over the layer-2 output map.
- Requantizes each result to 8 bits, applies 2x2 max-pooling and writes pooled values with addresses toward the layer-3 feature buffer.
- Sits directly downstream of the layer-2 MAC. Its start/done handshake is driven by the layer-2 controller.

---
 rtl/l2_pool_collector_pkg.sv | 36 +++
 rtl/l2_pool_collector_if.sv | 26 ++
 rtl/l2_pool_collector_pool_line_buffer.sv | 26 ++
 rtl/l2_pool_collector.sv | 149 ++++++++++++++
 tb/tb_l2_pool_collector.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/l2_pool_collector_pkg.sv
// Shared types and helpers for the layer-2 pooling collector.
// Build option L2_SAT_EN selects saturating requantization instead of truncation.
package l2_pkg;

  localparam int DW_IN  = 12;
  localparam int DW_OUT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // MAC result to output width; the two variants trade headroom for resolution
  function automatic logic [DW_OUT-1:0] quantize(input logic [DW_IN-1:0] d);
`ifdef L2_SAT_EN
    if (d > 12'd255) begin
      quantize = 8'hFF;
    end else begin
      quantize = d[DW_OUT-1:0];
    end
`else
    quantize = d[DW_IN-1 -: DW_OUT];
`endif
  endfunction

  function automatic logic [DW_OUT-1:0] max_u(input logic [DW_OUT-1:0] a,
                                              input logic [DW_OUT-1:0] b);
    if (a > b) begin
      max_u = a;
    end else begin
      max_u = b;
    end
  endfunction

endpackage

// File: rtl/l2_pool_collector_if.sv
// Stream and control bundle between the layer-2 MAC/controller and the pooling collector.
interface l2_pool_collector_if import l2_pkg::*; #(
  parameter int DW_IN  = l2_pkg::DW_IN,
  parameter int DW_OUT = l2_pkg::DW_OUT,
  parameter int AW     = 4
);
  logic              start;
  logic              done;
  logic              in_valid;
  logic [DW_IN-1:0]  in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DW_OUT-1:0] out_data;
  logic [AW-1:0]     out_addr;
  logic              out_ready;

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output done, in_ready, out_valid, out_data, out_addr
  );

  modport master (
    output start, in_valid, in_data, out_ready,
    input  done, in_ready, out_valid, out_data, out_addr
  );
endinterface

// File: rtl/l2_pool_collector_pool_line_buffer.sv
// One row of partial pooling maxima; written on even rows, read back on odd rows.
module pool_line_buffer import l2_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int DW    = l2_pkg::DW_OUT,
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [DW-1:0] wr_data,
  input  logic [IW-1:0] rd_idx,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Every entry is written on an even row before the odd row reads it, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/l2_pool_collector.sv
// Requantizes layer-2 MAC results, 2x2 max-pools them and emits addressed pooled values.
// Build option L2_SAT_EN (see l2_pkg::quantize) selects saturating requantization.
module l2_pool_collector import l2_pkg::*; #(
  parameter int MAP_W  = 8,
  parameter int MAP_H  = 8,
  parameter int DW_IN  = 12,
  parameter int DW_OUT = 8,
  parameter int AW     = 4
) (
  input  logic               clk,
  input  logic               rst,
  l2_pool_collector_if.slave bus
);

  localparam int CW  = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int RW  = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam int LBD = MAP_W / 2;
  localparam int LBW = (LBD > 1) ? $clog2(LBD) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(MAP_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(MAP_H - 1);

  state_t            state;
  state_t            next_state;
  logic [RW-1:0]     row;
  logic [CW-1:0]     col;
  logic [DW_OUT-1:0] hold;
  logic              frozen;
  logic              pool_valid;
  logic [DW_OUT-1:0] pool_data;
  logic [AW-1:0]     pool_addr;
  logic              done_flag;

  logic [DW_IN-1:0]  in_word;
  logic [DW_OUT-1:0] q;
  logic [DW_OUT-1:0] lb_rd;
  logic [LBW-1:0]    lb_idx;
  logic              in_ready;
  logic              accept;
  logic              out_fire;
  logic              last_pos;
  logic              enter_run;
  logic              lb_wr_en;
  logic              emit;

  assign in_word   = bus.in_data;
  assign q         = quantize(in_word);
  assign lb_idx    = LBW'(col >> 1);
  assign in_ready  = (state == RUN) && !frozen && (!pool_valid || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign out_fire  = pool_valid && bus.out_ready;
  assign last_pos  = (row == ROW_LAST) && (col == COL_LAST);
  assign enter_run = bus.start && (state != RUN);
  assign lb_wr_en  = accept && !row[0] && col[0];
  assign emit      = accept && row[0] && col[0];

  pool_line_buffer #(
    .DEPTH (LBD),
    .DW    (DW_OUT)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (lb_wr_en),
    .wr_idx  (lb_idx),
    .wr_data (max_u(hold, q)),
    .rd_idx  (lb_idx),
    .rd_data (lb_rd)
  );

  // Next-state decode; once counters freeze, the drain of the final output ends the frame
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.start) next_state = RUN;
        else           next_state = IDLE;
      end
      RUN: begin
        if (frozen && out_fire) next_state = DONE;
        else                    next_state = RUN;
      end
      DONE: begin
        if (bus.start) next_state = RUN;
        else           next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register and the registered done flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      done_flag <= 1'b0;
    end else begin
      state     <= next_state;
      done_flag <= (next_state == DONE);
    end
  end

  // Raster counters and the horizontal/vertical partial-max hold register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row    <= {RW{1'b0}};
      col    <= {CW{1'b0}};
      hold   <= {DW_OUT{1'b0}};
      frozen <= 1'b0;
    end else if (enter_run) begin
      row    <= {RW{1'b0}};
      col    <= {CW{1'b0}};
      hold   <= {DW_OUT{1'b0}};
      frozen <= 1'b0;
    end else if (accept) begin
      case ({row[0], col[0]})
        2'b00:   hold <= q;
        2'b10:   hold <= max_u(lb_rd, q);
        default: hold <= hold;
      endcase
      if (last_pos) begin
        frozen <= 1'b1;
      end else if (col == COL_LAST) begin
        col <= {CW{1'b0}};
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Output register; a new emit in the draining cycle simply overwrites the old value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pool_valid <= 1'b0;
      pool_data  <= {DW_OUT{1'b0}};
      pool_addr  <= {AW{1'b0}};
    end else if (emit) begin
      pool_valid <= 1'b1;
      pool_data  <= max_u(hold, q);
      pool_addr  <= AW'((int'(row) / 2) * (MAP_W / 2) + int'(col) / 2);
    end else if (out_fire) begin
      pool_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = pool_valid;
  assign bus.out_data  = pool_data;
  assign bus.out_addr  = pool_addr;
  assign bus.done      = done_flag;

endmodule

// File: tb/tb_l2_pool_collector.sv
// Directed scoreboard bench for l2_pool_collector (8x8 map); honours L2_SAT_EN like the design.
module tb_l2_pool_collector;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l2_pool_collector_if #(.DW_IN(12), .DW_OUT(8), .AW(4)) bus ();

  l2_pool_collector #(
    .MAP_W(8), .MAP_H(8), .DW_IN(12), .DW_OUT(8), .AW(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [11:0] stim [64];
  logic [11:0] exp_q [$];   // {addr[3:0], data[7:0]}
  bit          aborted;

  function automatic logic [7:0] ref_q(input logic [11:0] d);
`ifdef L2_SAT_EN
    return (d >= 12'd256) ? 8'd255 : 8'(d);
`else
    return 8'(d >> 4);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic build_expected();
    logic [7:0] m;
    logic [7:0] v;
    exp_q.delete();
    for (int pr = 0; pr < 4; pr++) begin
      for (int pc = 0; pc < 4; pc++) begin
        m = 8'd0;
        for (int a = 0; a < 2; a++) begin
          for (int b = 0; b < 2; b++) begin
            v = ref_q(stim[(2 * pr + a) * 8 + 2 * pc + b]);
            if (v > m) m = v;
          end
        end
        exp_q.push_back({4'(pr * 4 + pc), m});
      end
    end
  endtask

  // Runs one frame from a negedge; returns at a negedge after done (or after abort_at accepts)
  task automatic run_frame(input bit stall, input int start_at, input int abort_at);
    int         idx = 0;
    int         outs = 0;
    int         stall_cnt = 0;
    int         cyc = 0;
    bit         fin = 1'b0;
    bit         last;
    logic [11:0] e;
    aborted = 1'b0;
    build_expected();
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check("start_done_clear", bus.done, 0);
    check("start_in_ready", bus.in_ready, 1);
    while (!fin && cyc < 600) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = (idx < 64) ? stim[idx] : 12'hFFF;
      bus.out_ready = !stall || (stall_cnt >= 10);
      bus.start     = (cyc == start_at);
      #1;
      last = 1'b0;
      if (idx >= 64) check("frozen_in_ready", bus.in_ready, 0);
      if (bus.out_valid && !bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = exp_q[0];
          check("stall_data", bus.out_data, e[7:0]);
          check("stall_addr", bus.out_addr, e[11:8]);
          check("stall_in_ready", bus.in_ready, 0);
        end
        stall_cnt++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", bus.out_data, e[7:0]);
          check("out_addr", bus.out_addr, e[11:8]);
        end
        outs++;
        last = (outs == 16);
        if (last) check("done_low_at_last", bus.done, 0);
      end
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
      if (last) begin
        #1;
        check("done_after_last", bus.done, 1);
        check("valid_after_last", bus.out_valid, 0);
        check("ready_after_last", bus.in_ready, 0);
        fin = 1'b1;
      end
      if (abort_at > 0 && idx == abort_at) begin
        aborted = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    if (aborted) begin
      exp_q.delete();
    end else begin
      check("frame_finished", fin, 1);
      check("out_count", outs, 16);
      check("accept_count", idx, 64);
      check("queue_empty", exp_q.size(), 0);
      if (stall) check("stall_cycles", stall_cnt, 10);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
    check({tag, "_out_addr"}, bus.out_addr, 0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 12'h000;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_in_ready", bus.in_ready, 0);

    // Ramp, free-flowing sink
    for (int i = 0; i < 64; i++) stim[i] = 12'(i * 16);
    run_frame(1'b0, -1, 0);

    // Ramp again from DONE, with a stray start pulse mid-frame
    run_frame(1'b0, 30, 0);

    // Quantizer corner values
    for (int i = 0; i < 64; i++) stim[i] = 12'h300;
    run_frame(1'b0, -1, 0);
    for (int i = 0; i < 64; i++) stim[i] = 12'h0FF;
    run_frame(1'b0, -1, 0);

    // Backpressure on the first output
    for (int i = 0; i < 64; i++) stim[i] = 12'(i * 16);
    run_frame(1'b1, -1, 0);

    // Single hot window at row 2, col 3
    for (int i = 0; i < 64; i++) stim[i] = 12'h000;
    stim[2 * 8 + 3] = 12'hFF0;
    run_frame(1'b0, -1, 0);

    // Reset mid-frame, then a clean ramp frame
    for (int i = 0; i < 64; i++) stim[i] = 12'(i * 16);
    run_frame(1'b0, -1, 20);
    check("abort_reached", aborted, 1);
    check("abort_out_data_live", bus.out_data, 15);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_idle", bus.in_ready, 0);
    @(negedge clk);
    run_frame(1'b0, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
